tt_sweep_checker: RTL and testbench

Sequential stimulus/capture stage placed around one 4-input single-output AIG cone.
- Drives x0..x3 through all 16 minterms.
- Captures y0 for each minterm into a 16-bit truth table.
- Compares the captured table against an expected truth table supplied at start.
Used to confirm on hardware or in simulation that each synthesized NPN-class representative realizes its intended function.

---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_sweep_checker_popcount16.sv | 19 +
 rtl/tt_sweep_checker.sv | 172 +++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared constants and types for the truth-table sweep checker.
package tt_sweep_pkg;

    localparam int N_IN        = 4;
    localparam int TT_W        = 16;
    localparam int MAX_LATENCY = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef logic [N_IN-1:0] idx_t;

endpackage

// File: rtl/tt_sweep_checker_popcount16.sv
// Combinational population count of a 16-bit vector into 5 bits (0..16).
module tt_popcount16 (
    input  logic [15:0] i_vec,
    output logic [4:0]  o_cnt
);

    logic [4:0] w_sum;

    // Sum the set bits of the input vector.
    always_comb begin
        w_sum = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_sum = w_sum + {4'd0, i_vec[i]};
        end
    end

    assign o_cnt = w_sum;

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps a 4-input cone through all minterms, captures its truth table and compares it.
// Optional mismatch_cnt output enabled by TT_SWEEP_MISMATCH_COUNT_EN.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int TT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] exp_tt,
    output logic            busy,
    output logic            done,
    output logic            x0,
    output logic            x1,
    output logic            x2,
    output logic            x3,
    input  logic            y0,
    output logic [TT_W-1:0] tt,
    output logic            match
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
    ,
    output logic [4:0]      mismatch_cnt
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    idx_t            r_idx;
    idx_t            r_x;
    logic [TT_W-1:0] r_exp_tt;
    logic [TT_W-1:0] r_tt;
    logic            r_match;
    logic            r_busy;
    logic            r_done;
    logic            r_pipe_vld [0:LATENCY];
    idx_t            r_pipe_idx [0:LATENCY];
    logic            w_tok_vld;
    idx_t            w_tok_idx;

    assign w_tok_vld = r_pipe_vld[LATENCY];
    assign w_tok_idx = r_pipe_idx[LATENCY];

    // Next-state decode; start is refused while the done pulse is still showing.
    always_comb begin
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DRIVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRIVE: begin
                if (r_idx == 4'hF) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = DRIVE;
                end
            end
            DRAIN: begin
                if (w_tok_vld && (w_tok_idx == 4'hF)) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Token pipe: stage 0 is loaded alongside x, so the last stage names the minterm y0 reflects now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_idx[i] <= 4'h0;
            end
        end else begin
            r_pipe_vld[0] <= (r_state == DRIVE);
            r_pipe_idx[0] <= r_idx;
            for (int i = 1; i <= LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    // Sweep datapath: minterm drive, capture, final compare and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= 4'h0;
            r_x      <= 4'h0;
            r_exp_tt <= {TT_W{1'b0}};
            r_tt     <= {TT_W{1'b0}};
            r_match  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            if (w_accept) begin
                r_exp_tt <= exp_tt;
                r_tt     <= {TT_W{1'b0}};
                r_idx    <= 4'h0;
                r_match  <= 1'b0;
                r_busy   <= 1'b1;
            end else begin
                if (r_state == DRIVE) begin
                    r_x   <= r_idx;
                    r_idx <= r_idx + 4'h1;
                end
                if (w_tok_vld) begin
                    r_tt[w_tok_idx] <= y0;
                end
                if (r_state == FIN) begin
                    r_match <= (r_tt == r_exp_tt);
                    r_busy  <= 1'b0;
                end
            end
        end
    end

`ifdef TT_SWEEP_MISMATCH_COUNT_EN
    logic [4:0] w_pop;
    logic [4:0] r_mismatch_cnt;

    tt_popcount16 u_popcount (
        .i_vec (r_tt ^ r_exp_tt),
        .o_cnt (w_pop)
    );

    // Mismatch count register, loaded with the final compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch_cnt <= 5'd0;
        end else if (w_accept) begin
            r_mismatch_cnt <= 5'd0;
        end else if (r_state == FIN) begin
            r_mismatch_cnt <= w_pop;
        end else begin
            r_mismatch_cnt <= r_mismatch_cnt;
        end
    end

    assign mismatch_cnt = r_mismatch_cnt;
`endif

    assign busy  = r_busy;
    assign done  = r_done;
    assign x0    = r_x[0];
    assign x1    = r_x[1];
    assign x2    = r_x[2];
    assign x3    = r_x[3];
    assign tt    = r_tt;
    assign match = r_match;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: two checkers (combinational cone, and a 3-flop cone with LATENCY=3).
module tb_tt_sweep_checker;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [4:0]  cnt;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] exp0 = 16'h0, exp1 = 16'h0;
    logic [15:0] f0 = 16'h0, f1 = 16'h0;
    logic        busy0, busy1, done0, done1, match0, match1;
    logic [3:0]  xv0, xv1;
    logic [15:0] tt0, tt1;
    logic        y_0, y_1;
    logic        c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
    logic [4:0]  cnt0, cnt1;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   acc1 = -100;

    assign y_0 = f0[xv0];
    always @(posedge clk) begin
        c1 <= f1[xv1];
        c2 <= c1;
        c3 <= c2;
    end
    assign y_1 = c3;

    tt_sweep_checker #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .exp_tt(exp0),
        .busy(busy0), .done(done0),
        .x0(xv0[0]), .x1(xv0[1]), .x2(xv0[2]), .x3(xv0[3]),
        .y0(y_0), .tt(tt0), .match(match0)
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
        , .mismatch_cnt(cnt0)
`endif
    );

    tt_sweep_checker #(.LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .exp_tt(exp1),
        .busy(busy1), .done(done1),
        .x0(xv1[0]), .x1(xv1[1]), .x2(xv1[2]), .x3(xv1[3]),
        .y0(y_1), .tt(tt1), .match(match1)
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
        , .mismatch_cnt(cnt1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: tt bit i is the cone's value at minterm i; done comes 16+L+2 cycles after acceptance.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int acc, input int lat);
        exp_t r;
        for (int i = 0; i < 16; i++) r.tt[i] = f[i];
        r.match    = (r.tt == e);
        r.cnt      = 5'($countones(r.tt ^ e));
        r.done_cyc = acc + 16 + lat + 2;
        return r;
    endfunction

    // Monitor for the combinational-cone checker.
    logic pd0 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            chk("d0_done_width", {31'd0, pd0}, 32'd0);
            chk("d0_busy_at_done", {31'd0, busy0}, 32'd0);
            if (q0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d0_unexpected_done: got done, want none (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                chk("d0_tt", {16'd0, tt0}, {16'd0, e.tt});
                chk("d0_match", {31'd0, match0}, {31'd0, e.match});
                chk("d0_done_cycle", cyc, e.done_cyc);
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
                chk("d0_mismatch_cnt", {27'd0, cnt0}, {27'd0, e.cnt});
`endif
            end
        end
        pd0 <= done0;
    end

    // Monitor for the registered-cone checker, including the x sequence.
    logic pd1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= acc1 + 1 && cyc <= acc1 + 16)
            chk("d1_x_seq", {28'd0, xv1}, 32'(cyc - acc1 - 1));
        if (done1) begin
            chk("d1_done_width", {31'd0, pd1}, 32'd0);
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d1_unexpected_done: got done, want none (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("d1_tt", {16'd0, tt1}, {16'd0, e.tt});
                chk("d1_match", {31'd0, match1}, {31'd0, e.match});
                chk("d1_done_cycle", cyc, e.done_cyc);
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
                chk("d1_mismatch_cnt", {27'd0, cnt1}, {27'd0, e.cnt});
`endif
            end
        end
        pd1 <= done1;
    end

    task automatic wait_idle(input int d);
        int t = 0;
        while (((d == 0) ? (busy0 || done0) : (busy1 || done1)) && t < 200) begin
            @(negedge clk); t++;
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: dut %0d still busy after %0d cycles", d, t);
        end
    endtask

    task automatic wait_drain(input int d);
        int t = 0;
        while (((d == 0) ? q0.size() : q1.size()) > 0 && t < 200) begin
            @(negedge clk); t++;
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: dut %0d no done after %0d cycles", d, t);
        end
    endtask

    // One sweep; optionally clobber exp_tt right after acceptance.
    task automatic run(input int d, input logic [15:0] f, input logic [15:0] e, input bit clobber);
        int acc;
        wait_idle(d);
        @(negedge clk);
        acc = cyc + 1;
        if (d == 0) begin
            f0 = f; exp0 = e; start0 = 1'b1;
            q0.push_back(model(f, e, acc, 0));
        end else begin
            f1 = f; exp1 = e; start1 = 1'b1; acc1 = acc;
            q1.push_back(model(f, e, acc, 3));
        end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        if (clobber) begin
            if (d == 0) exp0 = 16'h0000; else exp1 = 16'h0000;
        end
        wait_drain(d);
    endtask

    initial begin : stim
        int acc;
        int t;
        logic [15:0] f, e;

        repeat (3) @(negedge clk);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_x0", {28'd0, xv0}, 32'd0);
        chk("rst_tt0", {16'd0, tt0}, 32'd0);
        chk("rst_match0", {31'd0, match0}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_tt1", {16'd0, tt1}, 32'd0);
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
        chk("rst_cnt0", {27'd0, cnt0}, 32'd0);
`endif
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 16'h06B1, 16'h06B1, 1'b0);
        run(0, 16'h06B1, 16'h06B0, 1'b0);
        chk("x_hold_0", {28'd0, xv0}, 32'h0000000F);
        run(1, 16'h8000, 16'h8000, 1'b0);

        // start held for 40 cycles: accepted at acc and acc+20 only.
        wait_idle(0);
        @(negedge clk);
        acc = cyc + 1;
        f0 = 16'hFFFF; exp0 = 16'hFFFF; start0 = 1'b1;
        q0.push_back(model(16'hFFFF, 16'hFFFF, acc, 0));
        q0.push_back(model(16'hFFFF, 16'hFFFF, acc + 20, 0));
        repeat (40) @(negedge clk);
        start0 = 1'b0;
        wait_drain(0);
        repeat (4) @(negedge clk);

        // Reset in the middle of a sweep.
        wait_idle(0);
        @(negedge clk);
        f0 = 16'h06B1; exp0 = 16'h06B1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t = 0;
        while (xv0 != 4'd7 && t < 40) begin @(negedge clk); t++; end
        chk("reach_index7", {28'd0, xv0}, 32'd7);
        rst0 = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_x", {28'd0, xv0}, 32'd0);
        chk("midrst_tt", {16'd0, tt0}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        repeat (25) @(negedge clk);
        run(0, 16'h5A3C, 16'h5A3C, 1'b0);

        run(0, 16'h06B1, 16'h06B1, 1'b1);
        run(1, 16'h06B1, 16'h06B1, 1'b1);

        for (int k = 0; k < 10; k++) begin
            f = 16'($urandom);
            case ($urandom_range(2, 0))
                0:       e = f;
                1:       e = f ^ (16'h0001 << $urandom_range(15, 0));
                default: e = 16'($urandom);
            endcase
            run(k % 2, f, e, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
